// File: rtl/pong_pkg.sv
// Shared encodings for the Pong match controller: FSM state codes,
// ball-unit result codes and winner codes.
package pong_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SERVE  = 3'd1;
    localparam logic [2:0] ST_PLAY   = 3'd2;
    localparam logic [2:0] ST_SCORED = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    localparam logic [1:0] RES_NONE  = 2'd0;
    localparam logic [1:0] RES_P1    = 2'd1;
    localparam logic [1:0] RES_P2    = 2'd2;

    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_P1    = 2'd1;
    localparam logic [1:0] WIN_P2    = 2'd2;

endpackage

// File: rtl/serve_timer.sv
// Loadable down-counter that times the serve countdown; it parks at zero
// and reports done while at zero and not being reloaded.
module serve_timer #(
    parameter int CNT_W = 25
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0) && !i_load;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match/serve controller: sequences start, serve countdown, rally,
// point and game-over, keeps both scores and decides the winner.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int WIN_BY_TWO  = 0,
    parameter int SERVE_DELAY = 25000000,
    parameter int AUTO_SERVE  = 0,
    parameter int CNT_W       = 25
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_start,
    input  logic [1:0]         i_game_result,
    output logic [2:0]         o_state,
    output logic               o_play_en,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic [1:0]         o_winner,
    output logic               o_serve_dir,
    output logic               o_point_pulse
);

    generate
        if (WIN_SCORE < 1 || WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win_score
            $error("pong_match_ctrl: WIN_SCORE out of range for SCORE_W");
        end
        if (SERVE_DELAY < 1) begin : g_bad_serve_delay
            $error("pong_match_ctrl: SERVE_DELAY must be at least 1");
        end
    endgenerate

    localparam logic [SCORE_W-1:0] MAX_SCORE  = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W:0]   LEAD_TWO   = (SCORE_W + 1)'(2);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);

    logic [2:0]         state_q, state_d;
    logic               start_q, start_edge;
    logic               timer_load, timer_done;
    logic               p1_pt, p2_pt, point, win;
    logic [SCORE_W-1:0] scorer_old, other_score, scorer_new;

    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               dir_q, dir_d, pulse_q, pulse_d, play_en_q, play_en_d;

    assign start_edge = i_start & ~start_q;

    always_comb begin
        p1_pt = 1'b0;
        p2_pt = 1'b0;
        if (state_q == ST_PLAY) begin
            case (i_game_result)
                RES_P1:   p1_pt = 1'b1;
                RES_P2:   p2_pt = 1'b1;
                RES_NONE: ;
                default:  ;
            endcase
        end
    end

    // Win check always looks at the post-increment score of the scorer.
    assign point       = p1_pt | p2_pt;
    assign scorer_old  = p1_pt ? p1_q : p2_q;
    assign other_score = p1_pt ? p2_q : p1_q;
    assign scorer_new  = (scorer_old == MAX_SCORE) ? MAX_SCORE : scorer_old + 1'b1;
    assign win = point && (scorer_new >= WIN_VAL) &&
                 ((WIN_BY_TWO == 0) ||
                  ({1'b0, scorer_new} >= {1'b0, other_score} + LEAD_TWO) ||
                  (scorer_new == MAX_SCORE));

    serve_timer #(
        .CNT_W(CNT_W)
    ) u_serve_timer (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_load     (timer_load),
        .i_load_val (SERVE_LOAD),
        .o_done     (timer_done)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d    = ST_SERVE;
                    timer_load = 1'b1;
                end
            end
            ST_SERVE: begin
                if (timer_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (point) state_d = win ? ST_OVER : ST_SCORED;
            end
            ST_SCORED: begin
                if ((AUTO_SERVE != 0) || start_edge) begin
                    state_d    = ST_SERVE;
                    timer_load = 1'b1;
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_d    = ST_SERVE;
                    timer_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p1_d      = p1_q;
        p2_d      = p2_q;
        winner_d  = winner_q;
        dir_d     = dir_q;
        pulse_d   = 1'b0;
        play_en_d = (state_d == ST_PLAY);
        if (point) begin
            pulse_d = 1'b1;
            if (p1_pt) begin
                p1_d  = scorer_new;
                dir_d = 1'b1;
                if (win) winner_d = WIN_P1;
            end else begin
                p2_d  = scorer_new;
                dir_d = 1'b0;
                if (win) winner_d = WIN_P2;
            end
        end
        if ((state_q == ST_OVER) && start_edge) begin
            p1_d     = '0;
            p2_d     = '0;
            winner_d = WIN_NONE;
            dir_d    = 1'b0;
        end
    end

    // start_q resets high so a switch held through reset cannot start a game.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            start_q   <= 1'b1;
            p1_q      <= '0;
            p2_q      <= '0;
            winner_q  <= WIN_NONE;
            dir_q     <= 1'b0;
            pulse_q   <= 1'b0;
            play_en_q <= 1'b0;
        end else begin
            start_q   <= i_start;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            winner_q  <= winner_d;
            dir_q     <= dir_d;
            pulse_q   <= pulse_d;
            play_en_q <= play_en_d;
        end
    end

    assign o_state       = state_q;
    assign o_play_en     = play_en_q;
    assign o_p1_score    = p1_q;
    assign o_p2_score    = p2_q;
    assign o_winner      = winner_q;
    assign o_serve_dir   = dir_q;
    assign o_point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: three differently parametrised instances share
// one clock and are compared against a behavioural match model.
module tb_pong_match_ctrl;

    localparam int N     = 3;
    localparam int MAXS  = 15;
    localparam int WIN   = 9;
    localparam int SD[N]   = '{4, 4, 1};
    localparam int WB2[N]  = '{0, 1, 1};
    localparam int AUTO[N] = '{0, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[N];
    logic       start[N];
    logic [1:0] res[N];
    logic [2:0] st_w[N];
    logic       pe_w[N];
    logic [3:0] p1_w[N];
    logic [3:0] p2_w[N];
    logic [1:0] win_w[N];
    logic       dir_w[N];
    logic       pulse_w[N];

    pong_match_ctrl #(.SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(0), .SERVE_DELAY(4),
                      .AUTO_SERVE(0), .CNT_W(3)) dut_a (
        .i_Clk(clk), .i_Rst(rst[0]), .i_start(start[0]), .i_game_result(res[0]),
        .o_state(st_w[0]), .o_play_en(pe_w[0]), .o_p1_score(p1_w[0]), .o_p2_score(p2_w[0]),
        .o_winner(win_w[0]), .o_serve_dir(dir_w[0]), .o_point_pulse(pulse_w[0]));

    pong_match_ctrl #(.SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(1), .SERVE_DELAY(4),
                      .AUTO_SERVE(1), .CNT_W(3)) dut_b (
        .i_Clk(clk), .i_Rst(rst[1]), .i_start(start[1]), .i_game_result(res[1]),
        .o_state(st_w[1]), .o_play_en(pe_w[1]), .o_p1_score(p1_w[1]), .o_p2_score(p2_w[1]),
        .o_winner(win_w[1]), .o_serve_dir(dir_w[1]), .o_point_pulse(pulse_w[1]));

    pong_match_ctrl #(.SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(1), .SERVE_DELAY(1),
                      .AUTO_SERVE(0), .CNT_W(2)) dut_c (
        .i_Clk(clk), .i_Rst(rst[2]), .i_start(start[2]), .i_game_result(res[2]),
        .o_state(st_w[2]), .o_play_en(pe_w[2]), .o_p1_score(p1_w[2]), .o_p2_score(p2_w[2]),
        .o_winner(win_w[2]), .o_serve_dir(dir_w[2]), .o_point_pulse(pulse_w[2]));

    // Match model: phase 0 idle, 1 serving, 2 rally, 3 point scored, 4 game over.
    int m_phase[N], m_left[N], m_p1[N], m_p2[N], m_win[N], m_dir[N], m_pulse[N], m_prev[N];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] obs_vec(int d);
        return {st_w[d], pe_w[d], p1_w[d], p2_w[d], win_w[d], dir_w[d], pulse_w[d]};
    endfunction

    function automatic logic [15:0] exp_vec(int d);
        return {3'(m_phase[d]), (m_phase[d] == 2), 4'(m_p1[d]), 4'(m_p2[d]),
                2'(m_win[d]), 1'(m_dir[d]), 1'(m_pulse[d])};
    endfunction

    task automatic model_reset(int d);
        m_phase[d] = 0; m_left[d] = 0; m_p1[d] = 0; m_p2[d] = 0;
        m_win[d] = 0; m_dir[d] = 0; m_pulse[d] = 0; m_prev[d] = 1;
    endtask

    task automatic model_step(int d);
        int pressed, mine, theirs, n;
        bit won;
        if (rst[d]) begin
            model_reset(d);
            return;
        end
        pressed = (start[d] && !m_prev[d]) ? 1 : 0;
        m_prev[d]  = start[d] ? 1 : 0;
        m_pulse[d] = 0;
        case (m_phase[d])
            0: if (pressed != 0) begin m_phase[d] = 1; m_left[d] = SD[d]; end
            1: begin
                m_left[d]--;
                if (m_left[d] == 0) m_phase[d] = 2;
            end
            2: if (res[d] == 2'd1 || res[d] == 2'd2) begin
                mine   = (res[d] == 2'd1) ? m_p1[d] : m_p2[d];
                theirs = (res[d] == 2'd1) ? m_p2[d] : m_p1[d];
                n = (mine + 1 > MAXS) ? MAXS : mine + 1;
                won = (n >= WIN) && (WB2[d] == 0 || n - theirs >= 2 || n == MAXS);
                if (res[d] == 2'd1) m_p1[d] = n; else m_p2[d] = n;
                m_dir[d]   = (res[d] == 2'd1) ? 1 : 0;
                m_pulse[d] = 1;
                if (won) m_win[d] = int'(res[d]);
                m_phase[d] = won ? 4 : 3;
            end
            3: if (AUTO[d] != 0 || pressed != 0) begin m_phase[d] = 1; m_left[d] = SD[d]; end
            4: if (pressed != 0) begin
                m_p1[d] = 0; m_p2[d] = 0; m_win[d] = 0; m_dir[d] = 0;
                m_phase[d] = 1; m_left[d] = SD[d];
            end
            default: m_phase[d] = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < N; d++) model_step(d);
        #1;
    endtask

    // Drives start presses until the rally begins, then delivers one point.
    task automatic score_point(int d, int who);
        int budget = 40;
        while (m_phase[d] != 2 && budget > 0) begin
            start[d] = (m_phase[d] == 0 || m_phase[d] == 3) ? ~start[d] : 1'b0;
            tick();
            budget--;
        end
        start[d] = 1'b0;
        total++;
        if (m_phase[d] != 2 || st_w[d] !== 3'd2) begin
            bad++;
            $display("FAIL reach_play dut%0d: got state=%0d want=2", d, st_w[d]);
        end
        res[d] = 2'(who);
        tick();
        res[d] = 2'd0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1; start[d] = 1'b1; res[d] = 2'd0;
            model_reset(d);
        end
        repeat (3) tick();
        for (int d = 0; d < N; d++) begin
            total++;
            if (obs_vec(d) !== 16'h0000) begin
                bad++;
                $display("FAIL reset_values dut%0d: got=%h want=0000", d, obs_vec(d));
            end
        end
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int d = 0; d < N; d++) begin
                total++;
                if (st_w[d] !== 3'd0) begin
                    bad++;
                    $display("FAIL held_start_idle dut%0d cyc%0d: got=%0d want=0", d, c, st_w[d]);
                end
            end
        end
        for (int d = 0; d < N; d++) start[d] = 1'b0;
        tick();
        for (int d = 0; d < N; d++) start[d] = 1'b1;
        tick();
        for (int d = 0; d < N; d++) begin
            total++;
            if (st_w[d] !== 3'd1 || pe_w[d] !== 1'b0) begin
                bad++;
                $display("FAIL press_to_serve dut%0d: got st=%0d en=%0d want st=1 en=0", d, st_w[d], pe_w[d]);
            end
        end
        for (int d = 0; d < N; d++) start[d] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            for (int d = 0; d < N; d++) begin
                total++;
                if (st_w[d] !== ((k >= SD[d]) ? 3'd2 : 3'd1) || pe_w[d] !== (k >= SD[d])) begin
                    bad++;
                    $display("FAIL serve_delay dut%0d k=%0d: got st=%0d en=%0d", d, k, st_w[d], pe_w[d]);
                end
            end
        end
    endtask

    task automatic test_point();
        res[0] = 2'd3;
        tick();
        res[0] = 2'd0;
        total++;
        if (obs_vec(0) !== 16'h5000 || obs_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL illegal_result: got=%h want=5000", obs_vec(0));
        end
        res[0] = 2'd1;
        tick();
        total++;
        if (obs_vec(0) !== 16'h6103 || obs_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL p1_point: got=%h want=6103", obs_vec(0));
        end
        res[0] = 2'd2;
        tick();
        res[0] = 2'd0;
        total++;
        if (obs_vec(0) !== 16'h6102 || obs_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL pulse_once_and_ignore: got=%h want=6102", obs_vec(0));
        end
    endtask

    task automatic test_win_no_lead();
        for (int i = 0; i < 7; i++) score_point(0, 1);
        total++;
        if (p1_w[0] !== 4'd8 || st_w[0] !== 3'd3 || win_w[0] !== 2'd0) begin
            bad++;
            $display("FAIL p1_at_eight: got p1=%0d st=%0d w=%0d want 8 3 0", p1_w[0], st_w[0], win_w[0]);
        end
        score_point(0, 1);
        total++;
        if (p1_w[0] !== 4'd9 || st_w[0] !== 3'd4 || win_w[0] !== 2'd1 || pe_w[0] !== 1'b0
            || obs_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL win_at_nine: got=%h want=%h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_win_by_two();
        int seq[4] = '{1, 2, 1, 1};
        int e1[4]  = '{9, 9, 10, 11};
        int e2[4]  = '{8, 9, 9, 9};
        int est[4] = '{3, 3, 3, 4};
        int ew[4]  = '{0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            score_point(1, 1);
            score_point(1, 2);
        end
        total++;
        if (p1_w[1] !== 4'd8 || p2_w[1] !== 4'd8 || st_w[1] !== 3'd3) begin
            bad++;
            $display("FAIL deuce_setup: got %0d-%0d st=%0d want 8-8 st=3", p1_w[1], p2_w[1], st_w[1]);
        end
        for (int i = 0; i < 4; i++) begin
            score_point(1, seq[i]);
            total++;
            if (p1_w[1] !== 4'(e1[i]) || p2_w[1] !== 4'(e2[i]) || st_w[1] !== 3'(est[i])
                || win_w[1] !== 2'(ew[i])) begin
                bad++;
                $display("FAIL win_by_two step%0d: got %0d-%0d st=%0d w=%0d want %0d-%0d st=%0d w=%0d",
                         i, p1_w[1], p2_w[1], st_w[1], win_w[1], e1[i], e2[i], est[i], ew[i]);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 14; i++) begin
            score_point(2, 1);
            score_point(2, 2);
        end
        total++;
        if (p1_w[2] !== 4'd14 || p2_w[2] !== 4'd14 || st_w[2] !== 3'd3) begin
            bad++;
            $display("FAIL fourteen_all: got %0d-%0d st=%0d", p1_w[2], p2_w[2], st_w[2]);
        end
        score_point(2, 2);
        total++;
        if (p2_w[2] !== 4'd15 || st_w[2] !== 3'd4 || win_w[2] !== 2'd2 || dir_w[2] !== 1'b0) begin
            bad++;
            $display("FAIL saturated_win: got p2=%0d st=%0d w=%0d dir=%0d want 15 4 2 0",
                     p2_w[2], st_w[2], win_w[2], dir_w[2]);
        end
    endtask

    task automatic test_auto_serve();
        start[1] = 1'b0;
        tick();
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        total++;
        if (obs_vec(1) !== 16'h2000) begin
            bad++;
            $display("FAIL restart_b: got=%h want=2000", obs_vec(1));
        end
        score_point(1, 1);
        total++;
        if (obs_vec(1) !== 16'h6103) begin
            bad++;
            $display("FAIL auto_point: got=%h want=6103", obs_vec(1));
        end
        tick();
        total++;
        if (obs_vec(1) !== 16'h2102) begin
            bad++;
            $display("FAIL scored_one_cycle: got=%h want=2102", obs_vec(1));
        end
        repeat (4) tick();
        total++;
        if (obs_vec(1) !== 16'h5102) begin
            bad++;
            $display("FAIL auto_replay: got=%h want=5102", obs_vec(1));
        end
    endtask

    task automatic test_over_restart_and_reset();
        start[0] = 1'b0;
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        total++;
        if (obs_vec(0) !== 16'h2000) begin
            bad++;
            $display("FAIL over_restart: got=%h want=2000", obs_vec(0));
        end
        tick();
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1;
            model_reset(d);
        end
        #1;
        for (int d = 0; d < N; d++) begin
            total++;
            if (obs_vec(d) !== 16'h0000) begin
                bad++;
                $display("FAIL async_reset dut%0d: got=%h want=0000", d, obs_vec(d));
            end
        end
        tick();
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
        tick();
        for (int d = 0; d < N; d++) begin
            total++;
            if (obs_vec(d) !== exp_vec(d) || st_w[d] !== 3'd0) begin
                bad++;
                $display("FAIL after_release dut%0d: got=%h want=%h", d, obs_vec(d), exp_vec(d));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < N; d++) begin
                rst[d] = 1'b0;
                if ($urandom_range(0, 2) == 0) start[d] = ~start[d];
                res[d] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
                if ($urandom_range(0, 299) == 0) begin
                    rst[d] = 1'b1;
                    model_reset(d);
                end
            end
            tick();
            for (int d = 0; d < N; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: got=%h want=%h", d, c, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b0; start[d] = 1'b0; res[d] = 2'd0;
        end
    endtask

    initial begin
        test_reset();
        test_point();
        test_win_no_lead();
        test_win_by_two();
        test_saturation();
        test_auto_serve();
        test_over_restart_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Parametrised match/serve controller for the Pong top level. It sequences start, serve countdown, rally, point and game-over. It keeps both players' scores, decides the winner (optional win-by-two) and drives the enable consumed by the paddle and ball units. It sits between the ball unit's point result and the display, 7-segment and paddle/ball enables.

Parameters:
SCORE_W, 4, width of each score counter; scores saturate at 2^SCORE_W-1
WIN_SCORE, 9, points needed to win; must satisfy 1 <= WIN_SCORE <= 2^SCORE_W-1 (elaboration error otherwise)
WIN_BY_TWO, 0, 1 = winner also needs a lead of at least 2
SERVE_DELAY, 25000000, cycles spent in SERVE before play starts; must be >= 1
AUTO_SERVE, 0, 1 = SCORED goes straight to SERVE without a start press
CNT_W, 25, serve counter width; must hold SERVE_DELAY-1

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  asynchronous, active-high reset
i_start  in  1  level; OR of the player switches
i_game_result  in  2  from the ball unit; 0 none, 1 P1 scored, 2 P2 scored, 3 illegal (ignored)
o_state  out  3  current state encoding
o_play_en  out  1  enable for paddles and ball
o_p1_score  out  SCORE_W  player 1 score
o_p2_score  out  SCORE_W  player 2 score
o_winner  out  2  0 none, 1 P1, 2 P2
o_serve_dir  out  1  0 = serve toward P1 (left), 1 = toward P2 (right)
o_point_pulse  out  1  one-cycle strobe on every accepted point

Behaviour:
- Reset values: state IDLE, o_play_en 0, scores 0, o_winner 0, o_serve_dir 0, o_point_pulse 0, serve counter 0.
- The start-edge register resets to 1, so a switch held through reset release does not start a game. A new press is needed.
- start_edge = i_start & ~start_q. start_q is updated every cycle in every state.
- States: IDLE=0, SERVE=1, PLAY=2, SCORED=3, OVER=4. Codes 5-7 return to IDLE on the next cycle.
- All outputs are registered. o_play_en is 1 exactly while the state is PLAY.
- IDLE: on start_edge, go to SERVE and load the counter with SERVE_DELAY-1.
- SERVE: counter decrements every cycle. The cycle it reads 0, go to PLAY. PLAY is entered SERVE_DELAY cycles after entering SERVE. start_edge is ignored.
- PLAY, i_game_result = 1 or 2:
  - compute the scorer's new score n = min(old+1, 2^SCORE_W-1).
  - register n and pulse o_point_pulse on the next cycle.
  - set o_serve_dir toward the conceding player: 1 if P1 scored, 0 if P2 scored.
- PLAY, i_game_result = 0 or 3: stay in PLAY, no change.
- Win check uses post-increment n, never the old value. A win is declared when n >= WIN_SCORE and either:
  - WIN_BY_TWO = 0, or
  - n >= other+2, or
  - n == 2^SCORE_W-1 (saturation forces a decision).
- On a win, go to OVER and set o_winner to the scorer. Otherwise go to SCORED.
- SCORED:
  - AUTO_SERVE = 0: go to SERVE on start_edge.
  - AUTO_SERVE = 1: go to SERVE on the next cycle.
  - The counter is reloaded on entry to SERVE.
- OVER: scores and o_winner hold. On start_edge:
  - clear both scores and o_winner, set o_serve_dir to 0, go to SERVE.
  - this takes one cycle; the cleared scores are visible together with state SERVE.
- A non-zero i_game_result outside PLAY is ignored. At most one point is accepted per PLAY visit, because PLAY exits on the same edge the point is taken.
- Asserting i_Rst mid-rally or mid-countdown forces all reset values immediately, asynchronously. Deassertion takes effect at the next i_Clk edge.

Decomposition:
- pong_pkg holds the state localparams (ST_IDLE..ST_OVER), the result codes (RES_NONE, RES_P1, RES_P2) and the winner codes.
- One sub-module: serve_timer, a loadable down-counter. Ports: i_Clk, i_Rst, i_load, i_load_val[CNT_W], o_done. o_done is high when the count is 0 and not loading.
- The FSM, score and win logic stay in pong_match_ctrl.

Test Plan:
1. Reset with i_start held high, release reset, keep i_start high 10 cycles -> state stays IDLE (0). Drop i_start, then raise it -> SERVE. With SERVE_DELAY=4, PLAY and o_play_en=1 exactly 4 cycles later.
2. In PLAY, drive i_game_result=1 for one cycle -> next cycle o_p1_score=1, o_point_pulse=1 for one cycle, o_serve_dir=1, state SCORED, o_play_en=0. i_game_result=3 in PLAY -> no change.
3. WIN_SCORE=9, WIN_BY_TWO=0, P1 at 8, P1 scores -> o_p1_score=9, state OVER, o_winner=1. Score 9 triggers the win with no extra point needed.
4. WIN_BY_TWO=1, scores 8-8, then P1, P2, P1, P1 -> 9-8 SCORED, 9-9 SCORED, 10-9 SCORED, 11-9 OVER with o_winner=1.
5. SCORE_W=4, WIN_BY_TWO=1, alternating points up to 14-14, then P2 scores -> o_p2_score=15 (saturated), OVER, o_winner=2.
6. In OVER, press start -> scores 0, o_winner 0, state SERVE. Assert i_Rst mid-SERVE -> IDLE and all outputs at reset values without waiting for a clock edge. With AUTO_SERVE=1, SCORED lasts exactly 1 cycle.
